func_interp: RTL and testbench

Pipelined linear interpolator that sits at the consumer end of an activation-function LUT inside each neural-network layer. It drives the LUT's 4-bit address, takes back the combinational `base` / `next_data` pair, and blends them with the input's fractional bits to produce an interpolated activation. It uses a valid/ready stream on both sides with a global stall on output backpressure.

---
 rtl/func_interp.sv | 110 +++++++++++
 tb/tb_func_interp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/func_interp.sv
// rtl/func_interp.sv - three-stage LUT linear interpolator with valid/ready streams
//
// Purpose: drives an activation-function LUT address from the integer bits of
// the incoming sample, then blends the returned base/next entries using the
// fractional bits. Output backpressure stalls the whole pipeline.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   in_x/in_valid/in_ready input sample stream (signed)
//   lut_addr               LUT address, integer bits of the sample in stage A
//   lut_base/lut_next      combinational LUT return (signed)
//   out_y/out_valid/out_ready  interpolated result stream (signed, saturated)
//   out_cnt                wrapping count of results accepted downstream
module func_interp #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [ADDR_W-1:0]       lut_addr,
  input  logic signed [WIDTH-1:0] lut_base,
  input  logic signed [WIDTH-1:0] lut_next,
  output logic signed [WIDTH-1:0] out_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        out_cnt
);

  localparam int FRAC_W = WIDTH - ADDR_W;

  logic                    stall;
  logic                    a_valid;
  logic signed [WIDTH-1:0] a_x;
  logic                    b_valid;
  logic signed [WIDTH-1:0] b_base;
  logic signed [WIDTH-1:0] b_next;
  logic [FRAC_W-1:0]       b_frac;

  logic signed [WIDTH:0]        diff;
  logic signed [WIDTH+FRAC_W:0] prod;
  logic signed [WIDTH+FRAC_W:0] shifted;
  logic signed [WIDTH+1:0]      y;
  logic signed [WIDTH+1:0]      y_sat;

  // Clamp bounds in the widened y domain.
  localparam logic signed [WIDTH+1:0] Y_MAX = $signed({3'b000, {(WIDTH-1){1'b1}}});
  localparam logic signed [WIDTH+1:0] Y_MIN = $signed({3'b111, {(WIDTH-1){1'b0}}});

  // A held output freezes every stage so nothing in flight is overwritten.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign lut_addr = a_x[WIDTH-1:FRAC_W];

  always_comb begin
    diff    = {b_next[WIDTH-1], b_next} - {b_base[WIDTH-1], b_base};
    // Fraction is zero-extended so it multiplies as a non-negative weight.
    prod    = $signed({{FRAC_W{diff[WIDTH]}}, diff}) *
              $signed({{(WIDTH+1){1'b0}}, b_frac});
    // Arithmetic shift: rounds toward minus infinity.
    shifted = prod >>> FRAC_W;
    // |shifted| < 2^WIDTH, so the low WIDTH+2 bits carry the full value.
    y       = {{2{b_base[WIDTH-1]}}, b_base} + shifted[WIDTH+1:0];
    if (y > Y_MAX) begin
      y_sat = Y_MAX;
    end else if (y < Y_MIN) begin
      y_sat = Y_MIN;
    end else begin
      y_sat = y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_x       <= '0;
      b_valid   <= 1'b0;
      b_base    <= '0;
      b_next    <= '0;
      b_frac    <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
    end else if (!stall) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_x <= in_x;
      end
      b_valid   <= a_valid;
      b_base    <= lut_base;
      b_next    <= lut_next;
      b_frac    <= a_x[FRAC_W-1:0];
      out_valid <= b_valid;
      if (b_valid) begin
        out_y <= y_sat[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (out_valid && out_ready) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_func_interp.sv
// tb/tb_func_interp.sv - scoreboard bench for func_interp
module tb_func_interp;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] in_x;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        lut_addr;
  logic signed [7:0] lut_base;
  logic signed [7:0] lut_next;
  logic signed [7:0] out_y;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_cnt;

  logic              in_ready4;
  logic [3:0]        lut_addr4;
  logic signed [7:0] lut_base4;
  logic signed [7:0] lut_next4;
  logic signed [7:0] out_y4;
  logic              out_valid4;
  logic [3:0]        out_cnt4;

  logic signed [7:0] tb_base [16];
  logic signed [7:0] tb_next [16];

  int n_vec  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  assign lut_base  = tb_base[lut_addr];
  assign lut_next  = tb_next[lut_addr];
  assign lut_base4 = tb_base[lut_addr4];
  assign lut_next4 = tb_next[lut_addr4];

  func_interp #(.WIDTH(8), .ADDR_W(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready),
    .lut_addr(lut_addr), .lut_base(lut_base), .lut_next(lut_next),
    .out_y(out_y), .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt)
  );

  func_interp #(.WIDTH(8), .ADDR_W(4), .CNT_W(4)) u_cnt4 (
    .clk(clk), .rst(rst), .in_x(in_x), .in_valid(in_valid), .in_ready(in_ready4),
    .lut_addr(lut_addr4), .lut_base(lut_base4), .lut_next(lut_next4),
    .out_y(out_y4), .out_valid(out_valid4), .out_ready(out_ready), .out_cnt(out_cnt4)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Default LUT: entries 0..7 = 16*i, 8..15 = 0; next of 7 is 7, next of 15 is 0.
  task automatic load_default_lut();
    for (int i = 0; i < 16; i++) tb_base[i] = (i < 8) ? 8'(16 * i) : 8'sh00;
    for (int i = 0; i < 16; i++) tb_next[i] = (i == 7) ? tb_base[7] : tb_base[(i + 1) % 16];
  endtask

  function automatic int ref_y(input logic [7:0] x);
    int a, f, b, n, p, q, y;
    a = int'(x[7:4]);
    f = int'(x[3:0]);
    b = tb_base[a];
    n = tb_next[a];
    p = (n - b) * f;
    if (p >= 0) q = p / 16;
    else        q = -((-p + 15) / 16);
    y = b + q;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] x, input int e);
    int budget;
    bit acc;
    in_x     = x;
    in_valid = 1'b1;
    budget   = 0;
    acc      = 1'b0;
    while (!acc && budget < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      budget++;
    end
    if (!acc) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0, expected 1 within 100 cycles");
    end else begin
      exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops on each downstream transfer; stall and handshake checks.
  bit                was_stall = 1'b0;
  logic signed [7:0] held_y;
  always @(negedge clk) begin
    if (rst) begin
      was_stall = 1'b0;
    end else begin
      check("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (was_stall) begin
        check("stall_hold_y", int'(out_y), int'(held_y));
        check("stall_hold_valid", int'(out_valid), 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_output: got out_y %0d, expected no output", out_y);
        end else begin
          check("out_y", int'(out_y), exp_q.pop_front());
          n_pop++;
        end
      end
      was_stall = out_valid && !out_ready;
      held_y    = out_y;
    end
  end

  initial begin
    int target;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b1;
    load_default_lut();

    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_cnt", int'(out_cnt), 0);
    check("rst_lut_addr", int'(lut_addr), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_y", int'(out_y), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single sample with latency check: 32 + (16*5)>>>4 = 37.
    send(8'h25, 37);
    in_valid = 1'b0;
    check("lut_addr_after_accept", int'(lut_addr), 2);
    @(negedge clk);
    check("lat_edge_n", int'(out_valid), 0);
    @(negedge clk);
    check("lat_edge_n1", int'(out_valid), 0);
    @(negedge clk);
    check("lat_edge_n2_valid", int'(out_valid), 1);
    check("lat_edge_n2_y", int'(out_y), 37);
    drain();
    check("cnt_single", int'(out_cnt), 1);

    // LUT edge entries.
    send(8'h7A, 112);
    send(8'hF8, 0);
    in_valid = 1'b0;
    drain();

    // Negative slope and floor rounding with a modified LUT.
    tb_base[1] = 8'sh70; tb_next[1] = 8'sh00;
    tb_base[2] = 8'sh00; tb_next[2] = 8'shFF;
    tb_base[3] = 8'sh7F; tb_next[3] = 8'sh80;
    send(8'h11, 105);   // 112 + floor(-112/16)
    send(8'h21, -1);    // 0 + floor(-1/16)
    send(8'h3F, -113);  // 127 + floor(-3825/16) = 127 - 240
    in_valid = 1'b0;
    drain();
    load_default_lut();
    check("cnt_after_directed", int'(out_cnt), 6);

    // Streaming with backpressure, from a clean counter.
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("pulse_rst_cnt", int'(out_cnt), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    target = n_pop + 20;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] xs;
          xs = 8'((i * 37 + 11) & 8'hFF);
          send(xs, ref_y(xs));
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 300 && n_pop < target; c++) begin
          out_ready = (c % 3 == 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", n_pop, target);
    check("stream_cnt", int'(out_cnt), 20);
    check("stream_cnt4", int'(out_cnt4), 4);

    // Asynchronous reset with three samples in flight.
    out_ready = 1'b0;
    send(8'h25, 37);
    send(8'h33, 51);
    send(8'h44, 68);
    in_valid = 1'b0;
    check("inflight_stalled", int'(in_ready), 0);
    @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_out_valid", int'(out_valid), 0);
    check("async_out_cnt", int'(out_cnt), 0);
    check("async_lut_addr", int'(lut_addr), 0);
    check("async_in_ready", int'(in_ready), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h25, 37);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_lat_n", int'(out_valid), 0);
    @(negedge clk);
    check("post_rst_lat_n1", int'(out_valid), 0);
    @(negedge clk);
    check("post_rst_lat_n2", int'(out_valid), 1);
    drain();
    check("post_rst_cnt", int'(out_cnt), 1);

    // Counter wrap: 17 transfers total since reset -> 4-bit counter shows 1.
    for (int i = 0; i < 16; i++) send(8'h25, 37);
    in_valid = 1'b0;
    drain();
    check("wrap_cnt16", int'(out_cnt), 17);
    check("wrap_cnt4", int'(out_cnt4), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
